// File: rtl/qpi_psram_responder.sv
`default_nettype none
// ============================================================================
// Module   : qpi_psram_responder
// Brief    : Device-side quad-SPI PSRAM responder backed by a 16-bit word RAM.
// Revision : 1.0 - initial release
// ============================================================================
module qpi_psram_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_WAIT = 6
) (
    input  logic       mem_clk,
    input  logic       rst,
    input  logic       mem_ce,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic       qpi_mode,
    output logic [7:0] rst_count,
    output logic       cmd_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_SPI_CMD, S_QPI_CMD, S_ADDR, S_WAIT, S_RD_DATA, S_WR_DATA, S_IGNORE
    } state_t;

    localparam logic [7:0] C_CMD_RSTEN = 8'h66;
    localparam logic [7:0] C_CMD_RST   = 8'h99;
    localparam logic [7:0] C_CMD_QPI   = 8'h35;
    localparam logic [7:0] C_CMD_READ  = 8'hEB;
    localparam logic [7:0] C_CMD_WRITE = 8'h38;
    localparam logic [3:0] C_WAIT_LAST = 4'(READ_WAIT - 1);

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [6:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [1:0]        nib_q, nib_d;
    logic [11:0]       wsr_q, wsr_d;
    logic [11:0]       word_q, word_d;
    logic [3:0]        sio_out_q, sio_out_d;
    logic              oe_q, oe_d;
    logic              qpi_q, qpi_d;
    logic              rsten_q, rsten_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic [7:0]        rstcnt_q, rstcnt_d;

    logic [15:0]       ram [0:(1<<ADDR_W)-1];
    logic [15:0]       rd_data_q;
    logic              ram_re_w;
    logic              ram_we_w;
    logic [ADDR_W-1:0] ram_raddr_w;
    logic [15:0]       ram_wdata_w;
    logic [7:0]        cmd_w;
    logic [ADDR_W-1:0] addr_sh_w;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cmd_d       = cmd_q;
        wa_d        = wa_q;
        wcnt_d      = wcnt_q;
        nib_d       = nib_q;
        wsr_d       = wsr_q;
        word_d      = word_q;
        sio_out_d   = sio_out_q;
        oe_d        = oe_q;
        qpi_d       = qpi_q;
        rsten_d     = rsten_q;
        err_d       = 1'b0;
        rd_d        = rd_q;
        rstcnt_d    = rstcnt_q;
        ram_re_w    = 1'b0;
        ram_we_w    = 1'b0;
        ram_raddr_w = wa_q;
        ram_wdata_w = {wsr_q, sio_in};
        addr_sh_w   = ADDR_W'({wa_q, sio_in});
        cmd_w       = qpi_q ? {cmd_q[3:0], sio_in} : {cmd_q, sio_in[0]};

        if (mem_ce) begin
            state_d = S_IDLE;
            k_d     = 3'd0;
            cmd_d   = 7'd0;
            wcnt_d  = 4'd0;
            nib_d   = 2'd0;
            wsr_d   = 12'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    k_d     = 3'd1;
                    cmd_d   = qpi_q ? {3'd0, sio_in} : {6'd0, sio_in[0]};
                    state_d = qpi_q ? S_QPI_CMD : S_SPI_CMD;
                end
                S_SPI_CMD, S_QPI_CMD: begin
                    cmd_d = cmd_w[6:0];
                    k_d   = k_q + 3'd1;
                    if (state_q == S_QPI_CMD || k_q == 3'd7) begin
                        state_d = S_IGNORE;
                        rsten_d = 1'b0;
                        case (cmd_w)
                            C_CMD_RSTEN: rsten_d = 1'b1;
                            C_CMD_RST: begin
                                if (rsten_q) begin
                                    rstcnt_d = (rstcnt_q == 8'hFF) ? rstcnt_q : rstcnt_q + 8'd1;
                                    qpi_d    = 1'b0;
                                end
                            end
                            C_CMD_QPI: begin
                                if (qpi_q) err_d = 1'b1;
                                else       qpi_d = 1'b1;
                            end
                            C_CMD_READ, C_CMD_WRITE: begin
                                // Memory bursts exist only in QPI mode
                                if (qpi_q) begin
                                    state_d = S_ADDR;
                                    rd_d    = (cmd_w == C_CMD_READ);
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                S_ADDR: begin
                    wa_d = addr_sh_w;
                    k_d  = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        ram_re_w    = rd_q;
                        ram_raddr_w = addr_sh_w;
                        wcnt_d      = 4'd0;
                        nib_d       = 2'd0;
                        state_d     = rd_q ? S_WAIT : S_WR_DATA;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q == C_WAIT_LAST) begin
                        sio_out_d = rd_data_q[15:12];
                        word_d    = rd_data_q[11:0];
                        oe_d      = 1'b1;
                        nib_d     = 2'd1;
                        state_d   = S_RD_DATA;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
                S_RD_DATA: begin
                    nib_d = nib_q + 2'd1;
                    case (nib_q)
                        2'd0: begin
                            sio_out_d = rd_data_q[15:12];
                            word_d    = rd_data_q[11:0];
                        end
                        2'd1: sio_out_d = word_q[11:8];
                        2'd2: begin
                            // Prefetch next word; current word is held in word_q
                            sio_out_d   = word_q[7:4];
                            wa_d        = wa_q + 1'b1;
                            ram_re_w    = 1'b1;
                            ram_raddr_w = wa_q + 1'b1;
                        end
                        default: sio_out_d = word_q[3:0];
                    endcase
                end
                S_WR_DATA: begin
                    wsr_d = {wsr_q[7:0], sio_in};
                    nib_d = nib_q + 2'd1;
                    if (nib_q == 2'd3) begin
                        ram_we_w = 1'b1;
                        wa_d     = wa_q + 1'b1;
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 3'd0;
            cmd_q     <= 7'd0;
            wa_q      <= '0;
            wcnt_q    <= 4'd0;
            nib_q     <= 2'd0;
            wsr_q     <= 12'd0;
            word_q    <= 12'd0;
            sio_out_q <= 4'd0;
            oe_q      <= 1'b0;
            qpi_q     <= 1'b0;
            rsten_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            rstcnt_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cmd_q     <= cmd_d;
            wa_q      <= wa_d;
            wcnt_q    <= wcnt_d;
            nib_q     <= nib_d;
            wsr_q     <= wsr_d;
            word_q    <= word_d;
            sio_out_q <= sio_out_d;
            oe_q      <= oe_d;
            qpi_q     <= qpi_d;
            rsten_q   <= rsten_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            rstcnt_q  <= rstcnt_d;
        end
    end

    // RAM contents survive reset by design
    always_ff @(posedge mem_clk) begin
        if (ram_we_w) ram[wa_q] <= ram_wdata_w;
        if (ram_re_w) rd_data_q <= ram[ram_raddr_w];
    end

    assign sio_out   = sio_out_q;
    assign sio_oe    = oe_q & ~mem_ce;
    assign qpi_mode  = qpi_q;
    assign rst_count = rstcnt_q;
    assign cmd_err   = err_q;

endmodule
`default_nettype wire

// File: doc/qpi_psram_responder.md
Name: qpi_psram_responder

Overview:
- Synthesizable device-side responder for the quad-SPI PSRAM link: it plays the memory end of the bus driven by the team's PSRAM controller.
- Decodes SPI-mode init commands (RSTEN/RST/enter-QPI) and QPI read (0xEB) and write (0x38) bursts.
- Backed by an internal 16-bit word RAM.
- Used in loopback benches and on-board self-test in place of the LY68L6400.

Parameters:
- ADDR_W, 10, word-address bits of internal RAM (depth 2^ADDR_W x 16).
- READ_WAIT, 6, wait cycles between last address nibble and first read-data nibble (legal range 2..15).

Ports:
- mem_clk  in  1  bus clock; all sampling and state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_ce  in  1  chip enable, active low; high = bus idle.
- sio_in  in  4  sampled SIO bus (in SPI mode only bit 0 carries data).
- sio_out  out  4  read data driven toward the controller.
- sio_oe  out  1  output enable for sio_out; the tristate buffer lives at the top level.
- qpi_mode  out  1  1 once enter-QPI (0x35) has been accepted.
- rst_count  out  8  count of accepted RST commands, saturating at 255.
- cmd_err  out  1  one-cycle pulse when an unsupported command is decoded.

Behaviour:
- Reset values: sio_out=0, sio_oe=0, qpi_mode=0, rst_count=0, cmd_err=0; FSM=IDLE, rst_en=0.
- RAM contents are not reset.
- Reset mid-transaction aborts it; any partial write word is discarded.
- Cycle index k counts posedges with mem_ce=0, starting at k=0. mem_ce=1 at any posedge returns FSM to IDLE, clears partial state and drops the internal oe register.
- sio_oe output = oe_reg AND NOT mem_ce, so the bus is released combinationally the moment mem_ce rises.
- States: IDLE, SPI_CMD, QPI_CMD, ADDR, WAIT, RD_DATA, WR_DATA, IGNORE.
- SPI_CMD (qpi_mode=0):
  - Shift sio_in[0] MSB-first over k=0..7; decode at k=7.
  - 0x66: set rst_en.
  - 0x99 with rst_en=1: rst_count+1, qpi_mode=0, rst_en=0.
  - 0x99 with rst_en=0: ignored, no error.
  - 0x35: qpi_mode=1.
  - Any other value: cmd_err pulse.
  - Any command other than 0x66 clears rst_en.
  - Bits after k=7: IGNORE until mem_ce=1.
- QPI_CMD (qpi_mode=1): high nibble at k=0, low nibble at k=1.
  - 0xEB or 0x38: go to ADDR.
  - 0x66/0x99: same rules as SPI mode; RST also returns to SPI mode.
  - Anything else: cmd_err, IGNORE.
- ADDR: k=2..7 shift six nibbles MSB-first into a 24-bit address; bit 23 ignored.
  - Word address = addr[ADDR_W-1:0]; higher bits ignored (aliasing).
- Read path:
  - At k=7, issue a synchronous RAM read of the word address; data is valid one cycle later.
  - WAIT lasts READ_WAIT cycles (k=8..7+READ_WAIT).
  - Data nibble j (j=0,1,2,...) is registered on the posedge of k=7+READ_WAIT+j, with oe_reg=1 from that same edge. It is therefore stable across the following negedge, where the controller samples.
  - Nibble order is [15:12], [11:8], [7:4], [3:0].
  - When nibble 2 of a word is driven, prefetch the next word (address+1, wrapping at 2^ADDR_W).
  - The burst continues until mem_ce=1.
- Write path: WR_DATA from k=8.
  - Nibbles are captured MSB-first into a 16-bit shift register.
  - On the 4th nibble, write the word to RAM at the current address and increment the address (wrap).
  - A partial word at mem_ce rise is discarded.
  - A write followed by a read of the same address in the next transaction returns the new data (write completes within the capture cycle).
- SPI-mode 0xEB/0x38 are unsupported: cmd_err.
- Simultaneous events: rst dominates everything; mem_ce=1 dominates any FSM advance on the same edge.

Test Plan:
- SPI 0x66, then 0x99, then 0x35 (each its own mem_ce frame): rst_count=1, qpi_mode=1, cmd_err never pulses.
- SPI 0x99 without a preceding 0x66: rst_count stays 0. SPI 0xAB: cmd_err pulses once at k=7 and the following bits are ignored.
- QPI write 0x38, addr 0x000010, data 0xABCD, then QPI read 0xEB at 0x000010: sio_out nibbles A,B,C,D at k=13..16 (READ_WAIT=6), sio_oe=1 from k=13.
- Burst write at 0x0003FF of 0x1111,0x2222 (ADDR_W=10), then read at 0x000000: returns 0x2222, confirming address wrap.
- Write frame with mem_ce raised after 6 data nibbles: first word committed, second discarded (a later read returns the old RAM value). sio_oe drops in the same cycle mem_ce rises during a read.
- Assert rst mid-read burst: sio_oe=0 immediately, qpi_mode=0, rst_count=0. RAM data written before the reset reads back correctly after re-init.
